// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon memory slave: FSM states, LFSR constants
// and the byte-enable width helper.
package avalon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Feedback mask for the right-shifting form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic int byte_en_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when stepped; reloads the seed on reset.
module lfsr16
    import avalon_pkg::*;
(
    input  logic        i_Clk,
    input  logic        i_Rst_n,
    input  logic        i_Step,
    output logic [15:0] o_Lfsr
);

    logic feedback;

    assign feedback = ^(o_Lfsr & LFSR_TAPS);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Lfsr <= LFSR_SEED;
        end else if (i_Step) begin
            o_Lfsr <= {feedback, o_Lfsr[15:1]};
        end
    end

endmodule

// File: rtl/avalon_mem_slave.sv
// Avalon-MM memory slave with fixed or LFSR-driven wait states, byte-enabled
// writes, transfer counters and a sticky protocol-error flag.
module avalon_mem_slave
    import avalon_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int ADDR_WIDTH            = 30,
    parameter int DEPTH                 = 64,
    parameter int NUM_PERIPH_SEL_BITS   = 5,
    parameter int PERIPH_SEL            = 0,
    parameter int WRITE_WAIT_REQ_CYCLES = 5,
    parameter int READ_WAIT_REQ_CYCLES  = 4,
    parameter int RANDOM_WAIT           = 0
) (
    input  logic                                  i_Clk,
    input  logic                                  i_Rst_n,
    input  logic [ADDR_WIDTH-1:0]                 i_AV_Addr,
    input  logic [byte_en_width(DATA_WIDTH)-1:0]  i_AV_ByteEn,
    input  logic                                  i_AV_Read,
    input  logic                                  i_AV_Write,
    input  logic [DATA_WIDTH-1:0]                 i_AV_WriteData,
    output logic [DATA_WIDTH-1:0]                 o_AV_ReadData,
    output logic                                  o_AV_WaitRequest,
    output logic [15:0]                           o_RdCount,
    output logic [15:0]                           o_WrCount,
    output logic                                  o_ProtoErr
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = byte_en_width(DATA_WIDTH);
    localparam int CNT_W = 16;

    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt, load_n;
    logic [15:0]            lfsr_val;
    logic                   sel, req, accept, changed;
    logic                   wr_commit, rd_done, err_set;
    logic [IDX_W-1:0]       idx;
    logic [ADDR_WIDTH-1:0]  cap_addr;
    logic [DATA_WIDTH-1:0]  cap_data;
    logic [BE_W-1:0]        cap_be;
    logic                   cap_read, cap_write;
    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    lfsr16 u_lfsr (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Step  (accept),
        .o_Lfsr  (lfsr_val)
    );

    assign sel = (i_AV_Addr[ADDR_WIDTH-1 -: NUM_PERIPH_SEL_BITS] == NUM_PERIPH_SEL_BITS'(PERIPH_SEL));
    assign req = sel && (i_AV_Read || i_AV_Write);
    assign idx = i_AV_Addr[IDX_W-1:0];

    assign load_n = (RANDOM_WAIT != 0) ? CNT_W'(lfsr_val & 16'h000F)
                  : (i_AV_Write ? CNT_W'(WRITE_WAIT_REQ_CYCLES) : CNT_W'(READ_WAIT_REQ_CYCLES));

    // Write data and byte enables only matter when the held request is a write
    assign changed = (i_AV_Addr != cap_addr) || (i_AV_Read != cap_read) || (i_AV_Write != cap_write)
                  || (cap_write && ((i_AV_WriteData != cap_data) || (i_AV_ByteEn != cap_be)));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        wr_commit = 1'b0;
        rd_done   = 1'b0;
        err_set   = sel && i_AV_Read && i_AV_Write;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    cnt_nxt   = load_n;
                    state_nxt = (load_n == '0) ? ST_ACK : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    err_set   = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    if (changed) begin
                        err_set = 1'b1;
                    end
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1)) begin
                        state_nxt = ST_ACK;
                    end
                end
            end
            ST_ACK: begin
                wr_commit = req && i_AV_Write;
                rd_done   = req && !i_AV_Write;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign o_AV_WaitRequest = req && (state != ST_ACK);
    assign o_AV_ReadData    = rd_done ? mem[idx] : '0;

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            o_RdCount  <= '0;
            o_WrCount  <= '0;
            o_ProtoErr <= 1'b0;
            cap_addr   <= '0;
            cap_data   <= '0;
            cap_be     <= '0;
            cap_read   <= 1'b0;
            cap_write  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (err_set) begin
                o_ProtoErr <= 1'b1;
            end
            if (wr_commit) begin
                o_WrCount <= o_WrCount + 16'd1;
            end
            if (rd_done) begin
                o_RdCount <= o_RdCount + 16'd1;
            end
            if (accept) begin
                cap_addr  <= i_AV_Addr;
                cap_data  <= i_AV_WriteData;
                cap_be    <= i_AV_ByteEn;
                cap_read  <= i_AV_Read;
                cap_write <= i_AV_Write;
            end
        end
    end

    // Storage is deliberately not reset; the FSM reset alone blocks a commit
    always_ff @(posedge i_Clk) begin
        if (wr_commit) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_AV_ByteEn[b]) begin
                    mem[idx][b*8 +: 8] <= i_AV_WriteData[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: doc/avalon_mem_slave.md
AVALON_MEM_SLAVE -- requirements
Module: avalon_mem_slave

Interface
REQ-001 Parameter DATA_WIDTH, default 32: data bus width; a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 30: word-address width.
REQ-003 Parameter DEPTH, default 64: number of storage words; a power of 2.
REQ-004 Parameter NUM_PERIPH_SEL_BITS, default 5: number of upper address bits used for decode.
REQ-005 Parameter PERIPH_SEL, default 0: decode value compared against the upper address bits.
REQ-006 Parameter WRITE_WAIT_REQ_CYCLES, default 5: wait cycles for a write in fixed mode.
REQ-007 Parameter READ_WAIT_REQ_CYCLES, default 4: wait cycles for a read in fixed mode.
REQ-008 Parameter RANDOM_WAIT, default 0: 1 selects LFSR-driven wait counts.
REQ-009 i_Clk  in  1  sole clock; all state changes on the rising edge.
REQ-010 i_Rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-011 i_AV_Addr  in  ADDR_WIDTH  word address.
REQ-012 i_AV_ByteEn  in  DATA_WIDTH/8  byte enables for writes.
REQ-013 i_AV_Read / i_AV_Write  in  1 each  read and write requests.
REQ-014 i_AV_WriteData  in  DATA_WIDTH  write data.
REQ-015 o_AV_ReadData  out  DATA_WIDTH  read data.
REQ-016 o_AV_WaitRequest  out  1  stall indication.
REQ-017 o_RdCount / o_WrCount  out  16 each  completed-transfer counters.
REQ-018 o_ProtoErr  out  1  sticky protocol-error flag.

Function
REQ-019 Selected SHALL mean i_AV_Addr[ADDR_WIDTH-1 -: NUM_PERIPH_SEL_BITS] == PERIPH_SEL.
REQ-020 The word index SHALL be i_AV_Addr[log2(DEPTH)-1:0]; intermediate address bits are ignored, so the array aliases.
REQ-021 An unselected request SHALL see o_AV_WaitRequest=0 and o_AV_ReadData=0, and SHALL have no other effect.
REQ-022 The FSM SHALL have three states, IDLE, WAIT and ACK, with transitions as follows.
- IDLE: on a selected request, load the counter with N and go to WAIT if N>0, otherwise go to ACK.
- WAIT: decrement the counter and go to ACK when the counter reaches 0.
- ACK: always return to IDLE.
REQ-023 o_AV_WaitRequest SHALL be combinational: 1 when a selected request is present and the state is not ACK, 0 otherwise.
REQ-024 Timing: a request first sampled at edge k SHALL see o_AV_WaitRequest drop during the cycle after edge k+N, and the transfer SHALL complete at the following edge.
REQ-025 N SHALL be WRITE_WAIT_REQ_CYCLES or READ_WAIT_REQ_CYCLES according to request type when RANDOM_WAIT=0.
REQ-026 When RANDOM_WAIT=1, N SHALL be lfsr[3:0].
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1.
- Advances one step on each IDLE-to-WAIT or IDLE-to-ACK transition.
REQ-027 A write SHALL commit at the end of ACK, updating only the bytes whose i_AV_ByteEn bit is 1; o_WrCount increments by 1 and wraps at 16'hFFFF.
REQ-028 A read SHALL drive the indexed word on o_AV_ReadData during ACK and 0 in all other states; o_RdCount increments at the end of ACK.
REQ-029 If the request deasserts during WAIT, the FSM SHALL return to IDLE next edge with no commit, no count change and o_ProtoErr set.
REQ-030 If i_AV_Read and i_AV_Write are both 1, the transfer SHALL be treated as a write and o_ProtoErr set.
REQ-031 If address, type or data change during WAIT, o_ProtoErr SHALL be set; values sampled in ACK SHALL be used.
REQ-032 A back-to-back request held through ACK SHALL restart from IDLE, giving a minimum of one idle cycle between transfers.

Reset
REQ-033 Reset SHALL put the FSM in IDLE, clear the counter, o_RdCount, o_WrCount and o_ProtoErr, and load the LFSR with 16'hACE1.
REQ-034 Storage SHALL NOT be reset; contents are undefined until written.
REQ-035 Reset asserted mid-transfer SHALL abort it with no commit.

Structure
REQ-036 A shared package avalon_pkg SHALL hold the FSM state enum, the LFSR seed and taps constant, and the byte-enable width function.
REQ-037 The LFSR SHALL be a sub-module, lfsr16, with step enable and seed on reset.

Verification
REQ-038 Fixed mode, N=5: write 32'h5A5A5A5A to addr 0 with ByteEn 4'hF -> 5 wait cycles, then one ACK cycle; o_WrCount=1.
REQ-039 Read addr 0, N=4 -> o_AV_WaitRequest low after 4 wait cycles, o_AV_ReadData=32'h5A5A5A5A in ACK, 0 afterwards; o_RdCount=1.
REQ-040 Write 32'h11223344 to addr 1 with ByteEn 4'b0101 over a prior value of 0 -> read returns 32'h00220044.
REQ-041 Address with upper bits != PERIPH_SEL -> o_AV_WaitRequest=0 immediately, memory and counters unchanged.
REQ-042 Drop i_AV_Write in WAIT -> return to IDLE, no commit, o_ProtoErr=1; a later reset clears it.
REQ-043 RANDOM_WAIT=1: 8 consecutive reads -> wait counts match the lfsr16 sequence from seed 16'hACE1, bits [3:0].
